sw_prio_enc: RTL and testbench
==============================

# sw_prio_enc

Parametrised, registered priority encoder for board switch/button inputs.
- Synchronises and debounces an N-bit raw request vector.
- Encodes the highest-priority active bit into an index with a valid flag and a change pulse.
- Optionally latches the first winner until cleared.
- Sits between the board `sw`/`btn` pins and the LED/seven-segment drivers in the top level.

## Interface
- `N`, 8, number of request inputs; power of two, ≥2
- `IDXW`, `$clog2(N)`, index width; derived, do not override
- `DEB`, 16, consecutive cycles an input must differ before the debounced value flips; ≥1
- `MSB_FIRST`, 0, 0: lowest set index wins; 1: highest set index wins

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `req`  in  N  raw asynchronous request inputs (switches)
- `clr`  in  1  release latched result (sticky build only; ignored otherwise)
- `db`  out  N  debounced request vector
- `idx`  out  IDXW  winning index
- `valid`  out  1  at least one request is active (or latched)
- `chg`  out  1  one-cycle pulse when `{valid,idx}` changes

## Operation
- Synchroniser: two flops per bit, `req` → `s1` → `s2`.
- Debounce, per bit i, with counter `cnt[i]` of width `$clog2(DEB+1)`:
  - `s2[i]==db[i]` → `cnt[i]<=0`.
  - `s2[i]!=db[i]` and `cnt[i]==DEB-1` → `db[i]<=s2[i]`, `cnt[i]<=0`.
  - Otherwise → `cnt[i]<=cnt[i]+1`.
  - A glitch shorter than DEB cycles never reaches `db`.
- Encode (combinational on `db`):
  - `MSB_FIRST=0`: lowest set bit wins. `MSB_FIRST=1`: highest set bit wins.
  - `db==0` → encoded valid=0, index=0.
- Output register (non-sticky build): `idx`/`valid` load the encoded result every cycle.
- `chg<=1` whenever the next `{valid,idx}` differs from the current value; otherwise 0.
- Reset (`rst==0` at an edge) clears `s1`, `s2`, `db`, all `cnt`, `idx`, `valid`, `chg` to 0.
  - Reset mid-debounce discards the partial count.
  - `chg` is not pulsed on reset entry or exit.

## Timing
- Count edges from the first edge that samples a new stable `req` value into `s1` (edge 1).
- `s2` updates at edge 2.
- `db` flips at edge DEB+2.
- `idx`/`valid`/`chg` update at edge DEB+3.
- `chg` is high for exactly one cycle per change.
- Simultaneous flips of several bits in the same cycle debounce independently. If they flip together, they land together.
- Input that reverts before DEB consecutive differing samples: `cnt` resets, and `db`, outputs and `chg` are unaffected.
- `db` is visible one cycle before the `idx`/`valid` it produces.

## Configuration
- Macro: `SW_PRIO_ENC_STICKY_EN`.
- Defined — two-state FSM:
  - IDLE:
    - `valid=0`.
    - Encoded valid at an edge → load `idx`, `valid<=1`, go to HELD.
    - `clr` is ignored in IDLE.
  - HELD:
    - `idx`/`valid` hold regardless of `db` changes.
    - `clr==1` at an edge → `valid<=0`, `idx<=0`, go to IDLE.
    - If requests are still active, re-capture happens on the following edge. This gives at least one cycle of `valid=0` between two captures.
  - `chg` follows the same rule (pulse on any `{valid,idx}` change).
  - Reset returns the FSM to IDLE.
- Undefined: no FSM, transparent registered encoder as described in Operation; `clr` has no effect.

## Test plan
- N=8, DEB=4, MSB_FIRST=0:
  - Reset, then hold `req=8'b0010_1000` → `db` changes at edge 6; `idx=3`, `valid=1` at edge 7; `chg=1` at edge 7 only.
  - From `db=8'b0010_1000`, pulse `req[1]` high for 3 cycles → `db`, `idx=3`, `chg=0` unchanged throughout.
  - Drop `req` to 0 and hold → `valid=0`, `idx=0`, `chg` one-cycle pulse, DEB+3 edges after the first sampling edge.
  - Assert `rst=0` when `cnt` is 2 into a flip, then release `rst` with `req` still `8'b0000_0100` → outputs 0 during reset, no `chg` on exit; `idx=2` appears DEB+3 edges after release.
- MSB_FIRST=1, hold `req=8'b0010_1000` → `idx=5`, `valid=1`.
- `SW_PRIO_ENC_STICKY_EN` defined:
  - Capture `idx=3`, then raise `req[1]` → `idx` stays 3.
  - Pulse `clr` for 1 cycle → `valid=0` for one cycle, then `idx=1`, `valid=1`, with `chg` pulsing on both changes.

Source files
------------

// File: rtl/sw_prio_enc.sv
// sw_prio_enc -- registered priority encoder for board switches/buttons.
//
// Each raw request bit is passed through a two-flop synchroniser and a
// per-bit debouncer. The debounced vector is priority-encoded, and the
// result is registered together with a one-cycle change pulse.
//
// Optional build macro: SW_PRIO_ENC_STICKY_EN
//   Defined:   the first winner is latched (IDLE/HELD FSM) until clr.
//   Undefined: transparent registered encoder; clr has no effect.
//
// Parameters:
//   N          number of request inputs (power of two, >= 2)
//   IDXW       index width, derived from N (do not override)
//   DEB        consecutive differing samples needed to flip a debounced bit
//   MSB_FIRST  0: lowest set index wins, 1: highest set index wins
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-low
//   req    in   raw asynchronous request inputs
//   clr    in   release latched result (sticky build only)
//   db     out  debounced request vector
//   idx    out  winning index
//   valid  out  at least one request active (or latched)
//   chg    out  one-cycle pulse when {valid,idx} changes
module sw_prio_enc #(
  parameter int N         = 8,
  parameter int IDXW      = $clog2(N),
  parameter int DEB       = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            clr,
  output logic [N-1:0]    db,
  output logic [IDXW-1:0] idx,
  output logic            valid,
  output logic            chg
);

  localparam int            CW      = $clog2(DEB + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);

  logic [N-1:0]    s1_reg;
  logic [N-1:0]    s2_reg;
  logic [N-1:0]    db_reg;
  logic [IDXW-1:0] enc_idx;
  logic            enc_valid;
  logic [IDXW-1:0] idx_reg;
  logic [IDXW-1:0] idx_next;
  logic            valid_reg;
  logic            valid_next;
  logic            chg_reg;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= req;
      s2_reg <= s1_reg;
    end
  end

  // Per-bit debouncer: a bit flips only after DEB consecutive samples that
  // disagree with the current debounced value; any agreeing sample restarts
  // the count, so short glitches never reach db.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg;
      logic          db_bit_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg    <= '0;
          db_bit_reg <= 1'b0;
        end else if (s2_reg[gi] == db_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          db_bit_reg <= s2_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end

      assign db_reg[gi] = db_bit_reg;
    end
  endgenerate

  // Priority encoder. The loop direction is chosen so the last assignment
  // made is the winning bit.
  always_comb begin
    enc_valid = |db_reg;
    enc_idx   = '0;
    if (MSB_FIRST == 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (db_reg[i]) enc_idx = IDXW'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (db_reg[i]) enc_idx = IDXW'(i);
      end
    end
  end

`ifdef SW_PRIO_ENC_STICKY_EN
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // IDLE captures the first encoded winner; HELD ignores db until clr.
  // Clearing returns to IDLE with valid low, so a still-active request is
  // re-captured one edge later, guaranteeing a cycle of valid=0 between.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (enc_valid) begin
          idx_next   = enc_idx;
          valid_next = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (clr) begin
          idx_next   = '0;
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        idx_next   = '0;
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end
`else
  logic unused_clr;
  assign unused_clr = clr;

  always_comb begin
    idx_next   = enc_idx;
    valid_next = enc_valid;
  end
`endif

  // Output register. chg compares the value about to be loaded with the
  // current one; reset forces everything to zero and the debounced vector
  // restarts at zero, so neither reset entry nor exit produces a pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      chg_reg   <= 1'b0;
    end else begin
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
      chg_reg   <= ({valid_next, idx_next} != {valid_reg, idx_reg});
    end
  end

  assign db    = db_reg;
  assign idx   = idx_reg;
  assign valid = valid_reg;
  assign chg   = chg_reg;

endmodule

// File: tb/tb_sw_prio_enc.sv
// Directed testbench for sw_prio_enc with N=8, DEB=4. A second instance
// with MSB_FIRST=1 shares the same stimulus.
module tb_sw_prio_enc;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       clr;
  logic [7:0] db_l;
  logic [2:0] idx_l;
  logic       valid_l;
  logic       chg_l;
  logic [7:0] db_m;
  logic [2:0] idx_m;
  logic       valid_m;
  logic       chg_m;

  int n_cmp = 0;
  int n_err = 0;

  sw_prio_enc #(.N(8), .DEB(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .req(req), .clr(clr),
    .db(db_l), .idx(idx_l), .valid(valid_l), .chg(chg_l)
  );

  sw_prio_enc #(.N(8), .DEB(4), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .req(req), .clr(clr),
    .db(db_m), .idx(idx_m), .valid(valid_m), .chg(chg_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_db,
                           input logic [2:0] e_idx, input logic e_valid, input logic e_chg);
    check({tag, ".db"},    {24'd0, db_l},    {24'd0, e_db});
    check({tag, ".idx"},   {29'd0, idx_l},   {29'd0, e_idx});
    check({tag, ".valid"}, {31'd0, valid_l}, {31'd0, e_valid});
    check({tag, ".chg"},   {31'd0, chg_l},   {31'd0, e_chg});
    $display("step %-14s req=%b db=%b idx=%0d valid=%0d chg=%0d", tag, req, db_l, idx_l, valid_l, chg_l);
  endtask

  initial begin
    rst = 1'b0;
    req = 8'h00;
    clr = 1'b0;
    tick();
    tick();
    tick();
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check_out("rst_exit", 8'h00, 3'd0, 1'b0, 1'b0);

    // Two bits rising together land together at edge DEB+2, outputs at DEB+3.
    req = 8'b0010_1000;
    for (int e = 1; e <= 5; e++) tick();
    check_out("e5_pre", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("e6_db", 8'h28, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("e7_out", 8'h28, 3'd3, 1'b1, 1'b1);
    check("msb_idx", {29'd0, idx_m}, 32'd5);
    check("msb_valid", {31'd0, valid_m}, 32'd1);
    tick();
    check_out("e8_chg_lo", 8'h28, 3'd3, 1'b1, 1'b0);

`ifndef SW_PRIO_ENC_STICKY_EN
    // Three-cycle glitch on req[1] must be filtered.
    req = 8'b0010_1010;
    tick();
    tick();
    tick();
    req = 8'b0010_1000;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("glitch", 8'h28, 3'd3, 1'b1, 1'b0);
    end

    // Release all requests.
    req = 8'h00;
    for (int e = 1; e <= 6; e++) tick();
    check_out("rel_e6", 8'h00, 3'd3, 1'b1, 1'b0);
    tick();
    check_out("rel_e7", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    check_out("rel_e8", 8'h00, 3'd0, 1'b0, 1'b0);

    // Reset two counts into a flip; the partial count must be discarded.
    req = 8'b0000_0100;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b0;
    tick();
    check_out("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check_out("mid_rst2", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_out("post_rst", (e == 6) ? 8'h04 : 8'h00, 3'd0, 1'b0, 1'b0);
    end
    tick();
    check_out("post_rst_e7", 8'h04, 3'd2, 1'b1, 1'b1);
    check("msb_idx2", {29'd0, idx_m}, 32'd2);
    tick();
    check_out("post_rst_e8", 8'h04, 3'd2, 1'b1, 1'b0);
`else
    // Latched winner ignores a newly active lower-index request.
    req = 8'b0010_1010;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_out("held", (k >= 5) ? 8'h2A : 8'h28, 3'd3, 1'b1, 1'b0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_out("clr", 8'h2A, 3'd0, 1'b0, 1'b1);
    tick();
    check_out("recap", 8'h2A, 3'd1, 1'b1, 1'b1);
    check("msb_recap", {29'd0, idx_m}, 32'd5);
    tick();
    check_out("recap_hold", 8'h2A, 3'd1, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
